mole_scheduler: RTL
===================

Name: mole_scheduler

Overview:
- Game sequencer for the whack-a-mole design; drives the mole position generator through a request/valid handshake.
- Times each mole's visible window and the gap after it, resolves button presses into hits or misses, and keeps score and a miss count.
- Sits between the debounced button inputs, the mole position generator, and the display/score logic.

Parameters:
- NUM_HOLES, 9: number of holes; legal positions are 0..NUM_HOLES-1.
- POS_W, 4: width of the position bus.
- UP_TICKS, 100: initial visible window, in ticks.
- MIN_UP_TICKS, 30: floor for the visible window.
- SPEED_STEP, 10: window reduction, in ticks, per level.
- HITS_PER_LEVEL, 5: hits needed per level-up.
- GAP_TICKS, 30: mole-down time between moles, in ticks.
- MAX_MISSES, 3: number of misses that ends the game.
- SCORE_W, 8: score width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle game-rate enable; all timers advance only on tick.
- start  in  1  one-cycle pulse; begins a game from IDLE or OVER.
- btn  in  NUM_HOLES  debounced one-cycle press pulses, one bit per hole.
- pos_req  out  1  request to the position generator for a new position.
- pos_valid  in  1  generator response strobe.
- pos_in  in  POS_W  candidate position, sampled when pos_valid=1.
- mole_valid  out  1  mole is visible.
- mole_pos  out  POS_W  current mole hole.
- hit_pulse  out  1  one-cycle pulse on a hit.
- miss_pulse  out  1  one-cycle pulse on a miss.
- score  out  SCORE_W  hit count.
- misses  out  2  miss count.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0, state=IDLE, window=UP_TICKS, prev_pos=NUM_HOLES (no previous position).

States:
- IDLE: on start, clear score, misses and level, set window=UP_TICKS, go to REQ.
- REQ: pos_req=1, held until pos_valid.
  - When pos_valid=1, accept pos_in only if pos_in<NUM_HOLES and pos_in!=prev_pos. Pos_req stays high through the accept cycle.
  - On accept: latch mole_pos=pos_in, load the timer with window, set mole_valid=1 on the next edge, go to UP.
  - On reject: stay in REQ with pos_req still high.
  - The generator may present a new pos_valid on any cycle.
- UP: decrement the timer on each tick.
  - btn[mole_pos]=1 gives a hit. This holds even if other bits are also set, and even if the timer expires in the same cycle (hit wins).
  - Any btn bit set without btn[mole_pos] gives a miss.
  - Timer reaching 0 with no press gives a miss.
  - On resolution:
    - mole_valid clears on the next edge.
    - hit_pulse or miss_pulse is asserted for exactly 1 cycle on that same edge.
    - prev_pos=mole_pos.
    - Load the timer with GAP_TICKS and go to GAP.
- GAP: btn ignored; decrement on tick; at 0 go to REQ.
- OVER: mole_valid=0, game_over=1. Score and misses hold until start, which behaves as from IDLE.

Counters:
- Score increments by 1 on a hit and saturates at 2^SCORE_W-1.
- Misses increment on a miss. When a miss makes misses==MAX_MISSES, the next state is OVER instead of GAP; miss_pulse still fires.
- Level-up: every HITS_PER_LEVEL-th hit, window=max(window-SPEED_STEP, MIN_UP_TICKS). The window register is sized for UP_TICKS and must not underflow.

Boundary rules:
- start outside IDLE/OVER is ignored.
- A tick and a resolution in the same cycle: resolution takes priority and the tick is not applied to the new timer.
- A timer loaded with 0 resolves on the first tick.
- rst mid-game aborts immediately to IDLE; pos_req drops asynchronously.

Optional Feature:
- MOLE_SCHED_SPEEDUP_EN defined: level-up window shrink as above.
- Undefined: window stays UP_TICKS for the whole game; the level logic is not built.

Test Plan:
- Reset mid-UP at score=3 -> next cycle all outputs 0, state IDLE, pos_req=0.
- start, generator returns pos 4 -> mole_valid=1, mole_pos=4. Press btn[4] after 10 ticks -> hit_pulse 1 cycle, score=1, mole_valid=0. After 30 ticks, pos_req=1.
- Generator returns 12, then 4 (equal to prev_pos), then 7 -> first two rejected with pos_req held; mole_pos=7 accepted.
- No press for 100 ticks, three times -> miss_pulse three times, misses=3, game_over=1. start -> score=0, misses=0, pos_req=1.
- btn=9'b000010001 with mole_pos=4 -> hit. btn[0] alone -> miss. btn[4] in the same cycle as timer expiry -> hit.
- With MOLE_SCHED_SPEEDUP_EN: after 5 hits the window is 90; after 40 hits it is floored at 30. Without the macro: after 40 hits the window is still 100.

Source files
------------

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer.
// Requests mole positions over a req/valid handshake, then times each mole's
// visible window and the following gap. Button presses become hits or misses,
// and the block keeps the score and the miss count.
// Optional feature: define MOLE_SCHED_SPEEDUP_EN to shrink the visible window
// by SPEED_STEP every HITS_PER_LEVEL hits, down to MIN_UP_TICKS. Without it
// the window stays at UP_TICKS and the level counter is not built.
module mole_scheduler #(
    parameter int NUM_HOLES      = 9,
    parameter int POS_W          = 4,
    parameter int UP_TICKS       = 100,
    parameter int MIN_UP_TICKS   = 30,
    parameter int SPEED_STEP     = 10,
    parameter int HITS_PER_LEVEL = 5,
    parameter int GAP_TICKS      = 30,
    parameter int MAX_MISSES     = 3,
    parameter int SCORE_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] btn,
    output logic                 pos_req,
    input  logic                 pos_valid,
    input  logic [POS_W-1:0]     pos_in,
    output logic                 mole_valid,
    output logic [POS_W-1:0]     mole_pos,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           misses,
    output logic                 game_over
);

    localparam int TMR_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int WIN_W   = $clog2(UP_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_UP,
        S_GAP,
        S_OVER
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [WIN_W-1:0]     window_q, window_d;
    logic [POS_W-1:0]     prev_pos_q, prev_pos_d;
    logic [POS_W-1:0]     mole_pos_q, mole_pos_d;
    logic                 mole_valid_q, mole_valid_d;
    logic                 hit_pulse_q, hit_pulse_d;
    logic                 miss_pulse_q, miss_pulse_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [1:0]           misses_q, misses_d;

`ifdef MOLE_SCHED_SPEEDUP_EN
    localparam int LVL_W = $clog2(HITS_PER_LEVEL + 1);
    logic [LVL_W-1:0]     lvl_cnt_q, lvl_cnt_d;
`endif

    logic timer_done;
    logic is_hit;
    logic is_press;

    // Timer expires on the tick that takes it to zero; a zero load expires on the first tick.
    assign timer_done = (timer_q <= TMR_W'(1));

    // Next-state and datapath update for the game sequencer.
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        window_d     = window_q;
        prev_pos_d   = prev_pos_q;
        mole_pos_d   = mole_pos_q;
        mole_valid_d = mole_valid_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        score_d      = score_q;
        misses_d     = misses_q;
`ifdef MOLE_SCHED_SPEEDUP_EN
        lvl_cnt_d    = lvl_cnt_q;
`endif
        is_hit       = btn[mole_pos_q];
        is_press     = |btn;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    score_d  = '0;
                    misses_d = '0;
                    window_d = WIN_W'(UP_TICKS);
`ifdef MOLE_SCHED_SPEEDUP_EN
                    lvl_cnt_d = '0;
`endif
                    state_d  = S_REQ;
                end
            end

            S_REQ: begin
                if (pos_valid && (pos_in < POS_W'(NUM_HOLES)) && (pos_in != prev_pos_q)) begin
                    mole_pos_d   = pos_in;
                    timer_d      = TMR_W'(window_q);
                    mole_valid_d = 1'b1;
                    state_d      = S_UP;
                end
            end

            S_UP: begin
                if (is_hit || is_press || (tick && timer_done)) begin
                    // Resolution beats the tick: the gap timer is loaded unmodified.
                    mole_valid_d = 1'b0;
                    prev_pos_d   = mole_pos_q;
                    timer_d      = TMR_W'(GAP_TICKS);
                    state_d      = S_GAP;
                    if (is_hit) begin
                        hit_pulse_d = 1'b1;
                        if (score_q != '1) begin
                            score_d = score_q + 1'b1;
                        end
`ifdef MOLE_SCHED_SPEEDUP_EN
                        if (lvl_cnt_q == LVL_W'(HITS_PER_LEVEL - 1)) begin
                            lvl_cnt_d = '0;
                            if (window_q >= WIN_W'(MIN_UP_TICKS + SPEED_STEP)) begin
                                window_d = window_q - WIN_W'(SPEED_STEP);
                            end else begin
                                window_d = WIN_W'(MIN_UP_TICKS);
                            end
                        end else begin
                            lvl_cnt_d = lvl_cnt_q + 1'b1;
                        end
`endif
                    end else begin
                        miss_pulse_d = 1'b1;
                        misses_d     = misses_q + 2'd1;
                        if ((misses_q + 2'd1) == 2'(MAX_MISSES)) begin
                            state_d = S_OVER;
                        end
                    end
                end else if (tick) begin
                    timer_d = timer_q - 1'b1;
                end
            end

            S_GAP: begin
                if (tick) begin
                    if (timer_done) begin
                        state_d = S_REQ;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            window_q     <= WIN_W'(UP_TICKS);
            prev_pos_q   <= POS_W'(NUM_HOLES);
            mole_pos_q   <= '0;
            mole_valid_q <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            score_q      <= '0;
            misses_q     <= '0;
`ifdef MOLE_SCHED_SPEEDUP_EN
            lvl_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            window_q     <= window_d;
            prev_pos_q   <= prev_pos_d;
            mole_pos_q   <= mole_pos_d;
            mole_valid_q <= mole_valid_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
`ifdef MOLE_SCHED_SPEEDUP_EN
            lvl_cnt_q    <= lvl_cnt_d;
`endif
        end
    end

    // pos_req and game_over decode straight from state so reset drops them at once.
    assign pos_req    = (state_q == S_REQ);
    assign game_over  = (state_q == S_OVER);
    assign mole_valid = mole_valid_q;
    assign mole_pos   = mole_pos_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign score      = score_q;
    assign misses     = misses_q;

endmodule
